// File: rtl/decode_issue.sv
// Decode/issue stage: splits RV32 R/I instructions, reads the register
// file with writeback bypass and holds the decoded bundle for execute.
module decode_issue #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            ex_stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_enable,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic            illegal_instr
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_rf [NUM_REGS];

    logic [6:0]        r_opcode;
    logic [4:0]        r_rd;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [6:0]        r_funct7;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_illegal;

    logic [6:0]        w_op;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_ready;
    logic              w_accept;
    logic              w_supported;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic [XLEN-1:0]   w_imm;

    logic              w_load;
    logic              w_load_imm;
    logic              w_illegal_nxt;
    logic              w_refresh1;
    logic              w_refresh2;

    // Handshake and raw field extraction from the incoming word
    always_comb begin
        w_op        = instr[6:0];
        w_rs1       = instr[19:15];
        w_rs2       = instr[24:20];
        w_ready     = !rst && ((r_state == S_EMPTY) || !ex_stall);
        w_accept    = instr_valid && w_ready;
        w_supported = (w_op == OP_R) || (w_op == OP_I);
        w_imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
    end

    // Operand read: same-cycle writeback wins over the stale entry; x0 is zero
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0) begin
            if (wb_en && (wb_rd == w_rs1)) begin
                w_rs1_val = wb_data;
            end else begin
                w_rs1_val = r_rf[w_rs1];
            end
        end
        if (w_rs2 != 5'd0) begin
            if (wb_en && (wb_rd == w_rs2)) begin
                w_rs2_val = wb_data;
            end else begin
                w_rs2_val = r_rf[w_rs2];
            end
        end
    end

    // State register: EMPTY/FULL occupancy of the execute slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a supported accept fills, an unstalled drain empties
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = w_supported ? S_FULL : S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_accept) begin
                    w_state_nxt = w_supported ? S_FULL : S_EMPTY;
                end else if (!ex_stall) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Output strobes: which held registers load or refresh this cycle
    always_comb begin
        w_load        = w_accept && w_supported;
        w_load_imm    = w_load && (w_op == OP_I);
        w_illegal_nxt = w_accept && !w_supported;
        w_refresh1    = (r_state == S_FULL) && ex_stall && wb_en &&
                        (r_rs1 != 5'd0) && (wb_rd == r_rs1);
        w_refresh2    = (r_state == S_FULL) && ex_stall && wb_en &&
                        (r_rs2 != 5'd0) && (wb_rd == r_rs2);
    end

    // Register file: x0 writes are dropped, reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    // Held decode bundle: only changes on issue or stalled writeback refresh
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode   <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_funct7   <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (w_load) begin
            r_opcode   <= w_op;
            r_rd       <= instr[11:7];
            r_funct3   <= instr[14:12];
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_funct7   <= instr[31:25];
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
        end else begin
            if (w_refresh1) begin
                r_rs1_data <= wb_data;
            end
            if (w_refresh2) begin
                r_rs2_data <= wb_data;
            end
        end
    end

    // Immediate only follows I-type issues so R-type leaves it quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm <= '0;
        end else if (w_load_imm) begin
            r_imm <= w_imm;
        end
    end

    // Single-cycle flag for a consumed unsupported opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal_nxt;
        end
    end

    assign instr_ready   = w_ready;
    assign ex_enable     = (r_state == S_FULL);
    assign opcode        = r_opcode;
    assign rd            = r_rd;
    assign funct3        = r_funct3;
    assign rs1           = r_rs1;
    assign rs2           = r_rs2;
    assign funct7        = r_funct7;
    assign rs1_data      = r_rs1_data;
    assign rs2_data      = r_rs2_data;
    assign imm           = r_imm;
    assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: hand-encoded instructions with
// expected fields and operands worked out by hand.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ex_stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_enable;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        illegal_instr;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] ADD_1_5_6  = 32'h006280B3;
    localparam logic [31:0] ADDI_2_5_M = 32'hFFF28113;
    localparam logic [31:0] ADD_3_6_5  = 32'h005301B3;
    localparam logic [31:0] ADD_4_0_5  = 32'h00500233;
    localparam logic [31:0] LUI_7      = 32'h123453B7;

    decode_issue dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .ex_stall      (ex_stall),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .ex_enable     (ex_enable),
        .opcode        (opcode),
        .rd            (rd),
        .funct3        (funct3),
        .rs1           (rs1),
        .rs2           (rs2),
        .funct7        (funct7),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        instr_valid = v;
        instr       = ins;
        wb_en       = we;
        wb_rd       = wa;
        wb_data     = wd;
    endtask

    initial begin
        rst         = 1'b1;
        ex_stall    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        #1;
        check("rst_ready", {31'b0, instr_ready}, 32'd0);
        check("rst_exen", {31'b0, ex_enable}, 32'd0);
        check("rst_rs1d", rs1_data, 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_op", {25'b0, opcode}, 32'd0);

        rst = 1'b0;
        #1;
        check("idle_ready", {31'b0, instr_ready}, 32'd1);
        step();
        check("idle_exen", {31'b0, ex_enable}, 32'd0);

        drive(1'b0, 32'h0, 1'b1, 5'd5, 32'd7);
        step();
        drive(1'b0, 32'h0, 1'b1, 5'd6, 32'd3);
        step();
        drive(1'b1, ADD_1_5_6, 1'b0, 5'd0, 32'h0);
        step();
        check("add_exen", {31'b0, ex_enable}, 32'd1);
        check("add_op", {25'b0, opcode}, 32'h33);
        check("add_rd", {27'b0, rd}, 32'd1);
        check("add_rs1", {27'b0, rs1}, 32'd5);
        check("add_rs2", {27'b0, rs2}, 32'd6);
        check("add_rs1d", rs1_data, 32'd7);
        check("add_rs2d", rs2_data, 32'd3);

        drive(1'b1, ADDI_2_5_M, 1'b0, 5'd0, 32'h0);
        step();
        check("addi_exen", {31'b0, ex_enable}, 32'd1);
        check("addi_op", {25'b0, opcode}, 32'h13);
        check("addi_rd", {27'b0, rd}, 32'd2);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_rs1d", rs1_data, 32'd7);
        check("addi_f7", {25'b0, funct7}, 32'h7F);

        drive(1'b1, ADD_3_6_5, 1'b0, 5'd0, 32'h0);
        step();
        check("r_imm_hold", imm, 32'hFFFFFFFF);
        check("r_rs1d", rs1_data, 32'd3);
        check("r_rs2d", rs2_data, 32'd7);
        check("r_f7", {25'b0, funct7}, 32'd0);

        drive(1'b1, ADD_1_5_6, 1'b1, 5'd5, 32'd9);
        step();
        check("byp_rs1d", rs1_data, 32'd9);
        check("byp_rs2d", rs2_data, 32'd3);

        drive(1'b1, ADD_4_0_5, 1'b1, 5'd0, 32'hDEAD);
        step();
        check("x0byp_rs1d", rs1_data, 32'd0);
        check("x0byp_rs2d", rs2_data, 32'd9);

        drive(1'b1, ADD_4_0_5, 1'b0, 5'd0, 32'h0);
        step();
        check("x0rd_rs1d", rs1_data, 32'd0);

        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("drain_exen", {31'b0, ex_enable}, 32'd0);
        check("drain_rs2d", rs2_data, 32'd9);
        check("drain_rd", {27'b0, rd}, 32'd4);

        drive(1'b1, ADD_1_5_6, 1'b0, 5'd0, 32'h0);
        step();
        check("pre_stall_exen", {31'b0, ex_enable}, 32'd1);
        ex_stall = 1'b1;
        drive(1'b1, ADDI_2_5_M, 1'b1, 5'd6, 32'd11);
        #1;
        check("stall_ready", {31'b0, instr_ready}, 32'd0);
        step();
        check("stall_exen", {31'b0, ex_enable}, 32'd1);
        check("stall_op", {25'b0, opcode}, 32'h33);
        check("stall_rs2d", rs2_data, 32'd11);
        check("stall_rs1d", rs1_data, 32'd9);
        drive(1'b1, ADDI_2_5_M, 1'b0, 5'd0, 32'h0);
        step();
        check("stall2_rd", {27'b0, rd}, 32'd1);
        check("stall2_exen", {31'b0, ex_enable}, 32'd1);
        ex_stall = 1'b0;
        #1;
        check("unstall_ready", {31'b0, instr_ready}, 32'd1);
        step();
        check("unstall_op", {25'b0, opcode}, 32'h13);
        check("unstall_rd", {27'b0, rd}, 32'd2);
        check("unstall_rs1d", rs1_data, 32'd9);

        drive(1'b1, ADD_3_6_5, 1'b0, 5'd0, 32'h0);
        step();
        check("rf_x6_rs1d", rs1_data, 32'd11);

        drive(1'b1, LUI_7, 1'b0, 5'd0, 32'h0);
        step();
        check("ill_pulse", {31'b0, illegal_instr}, 32'd1);
        check("ill_exen", {31'b0, ex_enable}, 32'd0);
        check("ill_op", {25'b0, opcode}, 32'h33);
        check("ill_rs1d", rs1_data, 32'd11);
        check("ill_rd", {27'b0, rd}, 32'd3);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("ill_clear", {31'b0, illegal_instr}, 32'd0);

        drive(1'b1, ADD_1_5_6, 1'b0, 5'd0, 32'h0);
        step();
        check("mid_full", {31'b0, ex_enable}, 32'd1);
        rst = 1'b1;
        drive(1'b1, ADD_1_5_6, 1'b0, 5'd0, 32'h0);
        #1;
        check("mid_ready", {31'b0, instr_ready}, 32'd0);
        step();
        check("mid_exen", {31'b0, ex_enable}, 32'd0);
        check("mid_rs1d", rs1_data, 32'd0);
        check("mid_op", {25'b0, opcode}, 32'd0);
        rst = 1'b0;
        step();
        check("post_exen", {31'b0, ex_enable}, 32'd1);
        check("post_rs1d", rs1_data, 32'd0);
        check("post_rs2d", rs2_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
